// File: rtl/dmem_copy_engine.sv
// Word-by-word memory-to-memory copy engine driving a single-port data memory.
// Latency: START accepted at edge k -> DONE in cycle k+1+2*LEN (one RD and one WR cycle per word).
// Backpressure: none; START is ignored while BUSY and requests are never queued.
module dmem_copy_engine #(
    parameter int MEM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic [31:0] i_src_addr,
    input  logic [31:0] i_dst_addr,
    input  logic [10:0] i_len,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_err,
    output logic [31:0] o_m_addr,
    output logic        o_m_rw,
    output logic [31:0] o_m_wd,
    input  logic [31:0] i_m_rd
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    localparam logic [32:0] MEM_BYTES = 33'(4 * MEM_WORDS);
    localparam logic [10:0] MAX_LEN   = 11'(MEM_WORDS);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_src;
    logic [31:0] r_dst;
    logic [10:0] r_cnt;
    logic [31:0] r_data;
    logic        r_err;

    logic [32:0] w_len_bytes;
    logic [32:0] w_src_end;
    logic [32:0] w_dst_end;
    logic        w_invalid;

    // Request validation; end addresses carry a 33rd bit so an address near
    // 2^32 cannot wrap around and pass the bounds check.
    assign w_len_bytes = {20'd0, i_len, 2'b00};
    assign w_src_end   = {1'b0, i_src_addr} + w_len_bytes;
    assign w_dst_end   = {1'b0, i_dst_addr} + w_len_bytes;
    assign w_invalid   = (i_src_addr[1:0] != 2'b00) || (i_dst_addr[1:0] != 2'b00) ||
                         (i_len > MAX_LEN) || (w_src_end > MEM_BYTES) ||
                         (w_dst_end > MEM_BYTES);

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: invalid or empty requests go straight to FIN.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_invalid || (i_len == 11'd0)) begin
                        w_next = S_FIN;
                    end else begin
                        w_next = S_RD;
                    end
                end
            end
            S_RD:    w_next = S_WR;
            S_WR:    w_next = (r_cnt == 11'd1) ? S_FIN : S_RD;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Memory port: only RD and WR touch the memory, everything else drives zeros.
    always_comb begin
        o_m_addr = 32'd0;
        o_m_rw   = 1'b0;
        o_m_wd   = 32'd0;
        case (r_state)
            S_RD: begin
                o_m_addr = r_src;
            end
            S_WR: begin
                o_m_addr = r_dst;
                o_m_rw   = 1'b1;
                o_m_wd   = r_data;
            end
            default: begin
                o_m_addr = 32'd0;
            end
        endcase
    end

    // Datapath: latch the request on acceptance, capture read data, advance pointers after each write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_src  <= 32'd0;
            r_dst  <= 32'd0;
            r_cnt  <= 11'd0;
            r_data <= 32'd0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_src <= i_src_addr;
                        r_dst <= i_dst_addr;
                        r_cnt <= i_len;
                        r_err <= w_invalid;
                    end
                end
                S_RD: begin
                    r_data <= i_m_rd;
                end
                S_WR: begin
                    r_src <= r_src + 32'd4;
                    r_dst <= r_dst + 32'd4;
                    r_cnt <= r_cnt - 11'd1;
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_busy = (r_state != S_IDLE);
    assign o_done = (r_state == S_FIN);
    assign o_err  = r_err;

endmodule

// File: tb/tb_dmem_copy_engine.sv
// Bench for dmem_copy_engine with a behavioural memory and a word-level copy model.
// Latency checks count cycles from the accepting edge; outputs sampled on the falling edge.
// The memory has no backpressure; reads are combinational, writes land on the rising edge.
module tb_dmem_copy_engine;

    localparam int MEM_WORDS = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src = 32'd0;
    logic [31:0] dst = 32'd0;
    logic [10:0] len = 11'd0;
    logic        busy, done, err, m_rw;
    logic [31:0] m_addr, m_wd, m_rd;

    logic [31:0] mem     [MEM_WORDS];
    logic [31:0] ld_mem  [MEM_WORDS];
    logic [31:0] exp_mem [MEM_WORDS];
    logic        ld = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        logic [10:0] len;
        logic        exp_err;
        int          exp_cyc;
    } vec_t;
    vec_t vecs[10];

    dmem_copy_engine #(.MEM_WORDS(MEM_WORDS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start),
        .i_src_addr(src), .i_dst_addr(dst), .i_len(len),
        .o_busy(busy), .o_done(done), .o_err(err),
        .o_m_addr(m_addr), .o_m_rw(m_rw), .o_m_wd(m_wd), .i_m_rd(m_rd)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, write on the rising edge; bulk preload from ld_mem.
    assign m_rd = mem[m_addr[11:2]];
    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < MEM_WORDS; i++) mem[i] <= ld_mem[i];
        end else if (m_rw) begin
            mem[m_addr[11:2]] <= m_wd;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    task automatic load_mem(input bit randomize_all);
        if (randomize_all) begin
            for (int i = 0; i < MEM_WORDS; i++) ld_mem[i] = $urandom;
        end
        @(negedge clk); ld = 1'b1;
        @(negedge clk); ld = 1'b0;
    endtask

    // Reference model: decides validity with wide integer arithmetic and applies the copy
    // one word at a time in ascending order to a snapshot of the memory.
    task automatic model_req(input logic [31:0] s, input logic [31:0] d, input logic [10:0] l,
                             output logic e, output int cyc);
        longint ls = s, ld_ = d, ll = l;
        e = (ls % 4 != 0) || (ld_ % 4 != 0) || (ll > MEM_WORDS) ||
            (ls + 4 * ll > 4 * MEM_WORDS) || (ld_ + 4 * ll > 4 * MEM_WORDS);
        exp_mem = mem;
        if (!e) begin
            for (longint i = 0; i < ll; i++) exp_mem[ld_ / 4 + i] = exp_mem[ls / 4 + i];
        end
        cyc = e ? 1 : 1 + 2 * int'(ll);
    endtask

    task automatic run_req(input logic [31:0] s, input logic [31:0] d, input logic [10:0] l,
                           input logic exp_err, input int exp_cyc, input bit pulse_again);
        logic me;
        int   mc;
        int   done_at = 0, ndone = 0, bad = 0;
        bit   busy_ok = 1, rw_ok = 1;
        logic err_at_done = 1'b0;
        model_req(s, d, l, me, mc);
        @(negedge clk);
        src = s; dst = d; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (pulse_again) begin
            start = 1'b1; src = s + 32'd4; dst = d + 32'd8; len = l + 11'd1;
        end
        for (int n = 1; n <= exp_cyc + 3; n++) begin
            @(negedge clk);
            if (n == 2) begin
                start = 1'b0; src = 32'hDEAD_BEEF; dst = 32'h1234_5678; len = 11'h7FF;
            end
            if (done) begin
                ndone++;
                if (done_at == 0) begin
                    done_at = n;
                    err_at_done = err;
                end
            end
            if (busy !== (n <= exp_cyc)) busy_ok = 0;
            if (m_rw !== ((n % 2 == 0) && (n < exp_cyc))) rw_ok = 0;
        end
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== exp_mem[i]) bad++;
        check($sformatf("done_cycle s=%0h d=%0h l=%0d", s, d, l), 64'(done_at), 64'(exp_cyc));
        check("done_pulses", 64'(ndone), 64'd1);
        check("err_at_done", 64'(err_at_done), 64'(exp_err));
        check("err_held", 64'(err), 64'(exp_err));
        check("busy_window", 64'(busy_ok), 64'd1);
        check("rw_pattern", 64'(rw_ok), 64'd1);
        check("mem_words_wrong", 64'(bad), 64'd0);
    endtask

    initial begin
        logic [31:0] s, d;
        logic [10:0] l;
        logic        e;
        int          c;
        int          changed;

        vecs[0] = '{32'h0,        32'h40,  11'd4,    1'b0, 9};
        vecs[1] = '{32'h0,        32'h40,  11'd0,    1'b0, 1};
        vecs[2] = '{32'h2,        32'h40,  11'd1,    1'b1, 1};
        vecs[3] = '{32'h0,        32'hFFC, 11'd2,    1'b1, 1};
        vecs[4] = '{32'hFFC,      32'h0,   11'd1,    1'b0, 3};
        vecs[5] = '{32'h0,        32'h0,   11'd1025, 1'b1, 1};
        vecs[6] = '{32'h1000,     32'h1000, 11'd0,   1'b0, 1};
        vecs[7] = '{32'hFFFF_FFFC, 32'h0,  11'd1,    1'b1, 1};
        vecs[8] = '{32'h0,        32'h0,   11'd1024, 1'b0, 2049};
        vecs[9] = '{32'h10,       32'h14,  11'd3,    1'b0, 7};

        // Reset state, clock running.
        #1;
        check("reset_outputs", 64'({busy, done, err, m_rw, m_addr, m_wd}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < MEM_WORDS; i++) ld_mem[i] = $urandom;
        ld_mem[0] = 32'd1; ld_mem[1] = 32'd9; ld_mem[2] = 32'd2; ld_mem[3] = 32'd3;
        load_mem(1'b0);

        for (int v = 0; v < 10; v++) begin
            run_req(vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].exp_err, vecs[v].exp_cyc, 1'b0);
            if (v == 0) begin
                check("word16", 64'(mem[16]), 64'd1);
                check("word17", 64'(mem[17]), 64'd9);
                check("word18", 64'(mem[18]), 64'd2);
                check("word19", 64'(mem[19]), 64'd3);
            end
        end

        // A second START in the cycle after acceptance, with other operands, must be ignored.
        load_mem(1'b1);
        run_req(32'h200, 32'h600, 11'd5, 1'b0, 11, 1'b1);

        // Reset during the third WR of a 10-word copy.
        load_mem(1'b1);
        exp_mem = mem;
        for (int i = 0; i < 2; i++) exp_mem[32'h400 / 4 + i] = exp_mem[32'h100 / 4 + i];
        @(negedge clk);
        src = 32'h100; dst = 32'h400; len = 11'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("third_wr_active", 64'(m_rw), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 64'({busy, done, err, m_rw, m_addr, m_wd}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        changed = 0;
        for (int i = 0; i < MEM_WORDS; i++) if (mem[i] !== exp_mem[i]) changed++;
        check("aborted_copy_mem", 64'(changed), 64'd0);
        run_req(32'h100, 32'h400, 11'd10, 1'b0, 21, 1'b0);

        // Randomized requests against the model.
        for (int t = 0; t < 24; t++) begin
            if (t % 6 == 0) load_mem(1'b1);
            l = 11'($urandom_range(0, 12));
            s = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            d = 32'($urandom_range(0, MEM_WORDS - 1)) << 2;
            if ($urandom_range(0, 7) == 0) s[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 7) == 0) d[1:0] = 2'($urandom_range(1, 3));
            model_req(s, d, l, e, c);
            run_req(s, d, l, e, c, (t % 5) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_copy_engine.md
DMEM_COPY_ENGINE -- requirements
Module: dmem_copy_engine

Interface
REQ-001 Parameter MEM_WORDS, default 1024, is the number of 32-bit words in the attached data memory.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  rising-edge clock shared with the data memory.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 START  input  1  request a copy; sampled only in IDLE.
REQ-006 SRC_ADDR  input  32  byte address of the first source word; latched on accepted START.
REQ-007 DST_ADDR  input  32  byte address of the first destination word; latched on accepted START.
REQ-008 LEN  input  11  word count, 0..MEM_WORDS; latched on accepted START.
REQ-009 BUSY  output  1  high from the cycle after an accepted START through the DONE cycle.
REQ-010 DONE  output  1  one-cycle completion pulse.
REQ-011 ERR  output  1  error flag for the last request; valid with DONE and held until the next accepted START.
REQ-012 M_ADDR  output  32  byte address to the data memory.
REQ-013 M_RW  output  1  0 = read, 1 = write; the memory writes on the CLK edge ending a cycle in which M_RW = 1.
REQ-014 M_WD  output  32  write data to the memory.
REQ-015 M_RD  input  32  combinational read data from the memory, valid in the same cycle when M_RW = 0.

Function
REQ-016 FSM states SHALL be IDLE, RD, WR and FIN, encoded in registers.
REQ-017 IDLE transitions:
- START = 1 and request invalid: go to FIN with ERR set.
- START = 1, request valid, LEN = 0: go to FIN with ERR clear.
- START = 1, request valid, LEN > 0: go to RD.
REQ-018 A request SHALL be invalid if SRC_ADDR[1:0] != 0, DST_ADDR[1:0] != 0, LEN > MEM_WORDS, or either address + 4*LEN > 4*MEM_WORDS; the end-address check SHALL use 33-bit arithmetic.
REQ-019 RD state:
- Drive M_ADDR = src pointer and M_RW = 0.
- Capture M_RD into the data register at the clock edge.
- Go to WR.
REQ-020 WR state:
- Drive M_ADDR = dst pointer, M_RW = 1 and M_WD = data register.
- At the clock edge, add 4 to both pointers and decrement the remaining count.
- Go to FIN if the remaining count was 1; otherwise go to RD.
REQ-021 FIN SHALL assert DONE for exactly one cycle and then return to IDLE.
REQ-022 In IDLE and FIN, M_RW SHALL be 0 and M_ADDR and M_WD SHALL be 0; no memory write occurs outside WR.
REQ-023 Throughput SHALL be 2 cycles per word: START accepted at edge k -> DONE high in cycle k+1+2*LEN.
REQ-024 START while BUSY SHALL be ignored; no queuing.
REQ-025 Words SHALL be copied in ascending address order; overlapping regions with DST_ADDR > SRC_ADDR are not preserved, and this SHALL NOT be flagged.
REQ-026 Changes on SRC_ADDR, DST_ADDR or LEN after acceptance SHALL NOT affect the transfer in progress.

Reset
REQ-027 RST_N low SHALL immediately force:
- State to IDLE.
- BUSY, DONE, ERR, M_RW = 0.
- M_ADDR, M_WD, pointers, count and data register = 0.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no further writes; words already written remain in memory.
REQ-029 After RST_N deasserts, the first START SHALL be accepted on the first rising edge.

Verification
REQ-030 Memory words 0..3 = 1, 9, 2, 3; START with SRC 0x0, DST 0x40, LEN 4 -> words 16..19 = 1, 9, 2, 3; DONE in cycle k+9; ERR 0.
REQ-031 LEN 0 -> DONE in cycle k+1; ERR 0; M_RW never 1.
REQ-032 SRC 0x2, or DST 0xFFC with LEN 2 -> DONE in cycle k+1; ERR 1; no memory write.
REQ-033 START pulsed in the cycle after acceptance with different SRC, DST and LEN -> ignored; first transfer completes unchanged; only one DONE pulse.
REQ-034 RST_N low during the 3rd WR of a LEN 10 copy -> outputs 0 immediately; only 2 destination words changed; the next START works normally.
REQ-035 LEN 1024, SRC 0, DST 0 -> 2048 cycles of alternating RD/WR; DONE in cycle k+2049; memory contents unchanged; ERR 0.
